// File: rtl/bpsk_serializer.sv
// bpsk_serializer: captures a flattened packet from the byte sorter and shifts
// it out LSB-first, one bit per CYCLES_PER_BIT clocks, for the BPSK modulator.
// Optional feature macro: BPSK_PREAMBLE_EN prepends an alternating 1,0,1,0...
// preamble of PREAMBLE_BITS bits ahead of the packet data.
module bpsk_serializer #(
  parameter int PACKET_WIDTH   = 2,
  parameter int CYCLES_PER_BIT = 4,
  parameter int PREAMBLE_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PACKET_WIDTH*8-1:0] sorted_packet,
  input  logic                      packet_ready,
  output logic                      tx_bit,
  output logic                      tx_valid,
  output logic                      symbol_start,
  output logic                      busy,
  output logic                      done
);

  localparam int NBITS   = PACKET_WIDTH * 8;
  localparam int CYC_W   = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BIT_MAX = (NBITS > PREAMBLE_BITS) ? NBITS : PREAMBLE_BITS;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(NBITS - 1);
`ifdef BPSK_PREAMBLE_EN
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
`endif

`ifdef BPSK_PREAMBLE_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DONE     = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic               ready_q;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [NBITS-1:0]   shreg;
  logic               start;
  logic               bit_wrap;

  // A start is a fresh rising edge of ready, honoured only while idle.
  assign start    = (state_q == IDLE) && packet_ready && !ready_q;
  assign bit_wrap = (cyc_cnt == CYC_LAST);

  // ready_q resets high so a level already present at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b1;
    else        ready_q <= packet_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: each active state ends on the wrap of its last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef BPSK_PREAMBLE_EN
          state_d = PREAMBLE;
`else
          state_d = DATA;
`endif
        end
      end
`ifdef BPSK_PREAMBLE_EN
      PREAMBLE: if (bit_wrap && (bit_cnt == PRE_LAST))  state_d = DATA;
`endif
      DATA:     if (bit_wrap && (bit_cnt == DATA_LAST)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Cycle and bit counters restart on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else if (state_d != state_q) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else if (tx_valid) begin
      if (bit_wrap) begin
        cyc_cnt <= '0;
        bit_cnt <= bit_cnt + BIT_W'(1);
      end else begin
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      end
    end
  end

  // Packet shift register: loaded on start, shifted right at each data bit boundary.
  always_ff @(posedge clk) begin
    if (start)                               shreg <= sorted_packet;
    else if ((state_q == DATA) && bit_wrap)  shreg <= shreg >> 1;
  end

  // Outputs decode straight from state so reset clears them immediately.
  always_comb begin
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    done     = 1'b0;
    case (state_q)
`ifdef BPSK_PREAMBLE_EN
      PREAMBLE: begin
        tx_valid = 1'b1;
        tx_bit   = ~bit_cnt[0];
      end
`endif
      DATA: begin
        tx_valid = 1'b1;
        tx_bit   = shreg[0];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign busy         = tx_valid;
  assign symbol_start = tx_valid && (cyc_cnt == '0);

endmodule

// File: doc/bpsk_serializer.md
# bpsk_serializer

Transmit-path stage directly downstream of the byte sorter. It captures the flattened packet once the sorter signals `ready`, then shifts the packet out one bit per symbol period, with each bit held for `CYCLES_PER_BIT` clocks. It produces the bit stream, qualifiers and symbol strobes consumed by the BPSK phase modulator. It can optionally prepend an alternating preamble for receiver carrier and bit sync.

## Interface
Parameters:
- `PACKET_WIDTH`, from `parameters.svh` (bench default 2): packet length in bytes.
- `CYCLES_PER_BIT`, 4: clocks per transmitted bit; must be ≥1.
- `PREAMBLE_BITS`, 16: preamble length in bits; used only with `BPSK_PREAMBLE_EN`; must be ≥1.

Ports:
- `clk`, in, 1: single clock; all logic is on `posedge clk`.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sorted_packet`, in, `PACKET_WIDTH*8`: flattened packet from the sorter; byte i sits at `[i*8 +: 8]`.
- `packet_ready`, in, 1: sorter `ready`; a level that stays high once set.
- `tx_bit`, out, 1: current data bit; 0 selects phase 0°, 1 selects phase 180°.
- `tx_valid`, out, 1: high while `tx_bit` carries a preamble or packet bit.
- `symbol_start`, out, 1: one-cycle pulse on the first clock of each bit period.
- `busy`, out, 1: high from capture until the end of the last bit period.
- `done`, out, 1: one-cycle pulse after the last bit period ends.

## Operation
- **States:** IDLE, PREAMBLE, DATA, DONE.
- **Start condition:** `ready_q` registers `packet_ready`. A start occurs on a rising edge, i.e. `packet_ready`=1 and `ready_q`=0, while in IDLE.
- **Capture (on start):**
  - `sorted_packet` is latched into the shift register, `PACKET_WIDTH*8` bits.
  - Next state is PREAMBLE with the macro defined, otherwise DATA.
- **Bit order:** byte 0 first; LSB first within each byte. Equivalently, `sorted_packet[0]` goes first and index ascends.
- **Preamble pattern:** alternating bits starting with 1 (1,0,1,0,…), `PREAMBLE_BITS` long. The last preamble bit is followed immediately by the first data bit, with no gap.
- **Counters:**
  - `cyc_cnt` counts 0..`CYCLES_PER_BIT`-1.
  - `bit_cnt` counts bits within the current state.
  - The shift register shifts right when `cyc_cnt` wraps.
  - Counter widths are `$clog2` of max+1, with a minimum of 1 bit.
- **End of packet:** after the last data bit period, the block spends one cycle in DONE and then returns to IDLE.
- **Re-arm:** a new packet requires `packet_ready` to fall and then rise again.
  - Rising edges seen while not in IDLE are ignored, not queued.
  - A level held high across DONE→IDLE does not restart transmission.
- **Input stability:** `sorted_packet` may change after capture without affecting the transmission in flight.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, counters are 0.
  - `ready_q` resets to 1, so a `packet_ready` that is already high at reset release does not start a transmission.
- **Mid-transmission reset:** reset asserted mid-transmission forces all outputs to 0 asynchronously and abandons the packet.
- **Latency:** rising edge sampled at edge N ⇒ at edge N+1, `busy`=1, `tx_valid`=1, `symbol_start`=1, and `tx_bit` = first bit.
- **Bit duration:** each bit holds for exactly `CYCLES_PER_BIT` cycles. `symbol_start` pulses on the first of them.
  - With `CYCLES_PER_BIT`=1, `symbol_start` stays high for every bit.
- **Active length:** `tx_valid` stays high for (`PREAMBLE_BITS`·[macro] + `PACKET_WIDTH*8`)·`CYCLES_PER_BIT` consecutive cycles.
- **Completion:** on the cycle after the last valid cycle, `done`=1, `busy`=0 and `tx_valid`=0.
- **Back-to-back packets:** the earliest next start is the IDLE cycle after DONE.

## Configuration
- **`BPSK_PREAMBLE_EN` defined:** the PREAMBLE state is compiled in, and the alternating preamble of `PREAMBLE_BITS` bits precedes the data.
- **`BPSK_PREAMBLE_EN` undefined:** there is no PREAMBLE state and the `PREAMBLE_BITS` parameter is unused. Capture goes directly to DATA, and the first valid bit is `sorted_packet[0]`.

## Test plan
All scenarios use `PACKET_WIDTH`=2, `CYCLES_PER_BIT`=4, `PREAMBLE_BITS`=8.
- **Basic packet, macro off:** `sorted_packet`=16'hA53C, `packet_ready` 0→1.
  - `tx_bit` sequence: 0,0,1,1,1,1,0,0, 1,0,1,0,0,1,0,1.
  - Each bit lasts 4 cycles; 64 valid cycles in total; then `done` pulses once.
- **Preamble, macro on:** same stimulus.
  - 1,0,1,0,1,0,1,0 precedes the data bits; 96 valid cycles; 24 `symbol_start` pulses.
- **Level hold and re-arm:**
  - `packet_ready` held high after `done` ⇒ no second transmission.
  - Drop `packet_ready` for 1 cycle, raise it with 16'h00FF ⇒ eight 1 bits, then eight 0 bits.
- **Ignored edge while busy:** toggle `packet_ready` and change `sorted_packet` mid-DATA ⇒ the current bit stream is unchanged and only one `done` occurs.
- **Reset mid-transmission:** assert `rst_n`=0 at bit 5 ⇒ all outputs are 0 immediately. Release it with `packet_ready` still high ⇒ the block stays IDLE.
- **`CYCLES_PER_BIT`=1:** 16'h0001 ⇒ `tx_bit`=1 for 1 cycle, then 0 for 15 cycles; `symbol_start` is high on all 16 cycles.
